viol_reset_seq: RTL and testbench

- Consumer end of the hw-mod violation lines. Each security monitor (atomicity, key access, DMA, stack) raises a level "reset" request when it sees a violation.
- This block turns those requests into one clean, timed CPU reset pulse. It then confirms the CPU re-entered through the reset vector and keeps a sticky record of why the reset happened.
- Sits between the monitors and the openMSP430 reset input.

---
 rtl/hwmod_pkg.sv | 25 ++
 rtl/sat_counter.sv | 38 +++
 rtl/viol_reset_seq.sv | 127 ++++++++++++
 tb/tb_viol_reset_seq.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/hwmod_pkg.sv
// Shared definitions for the hw-mod security monitors and the reset sequencer.
// Holds the sequencer state encoding, the CPU reset vector and default memory map bases.
// Also provides a counter-width helper so every counter gets at least one bit.
package hwmod_pkg;

  // Reset sequencer states
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ASSERT    = 2'd1,
    ST_WAIT_BOOT = 2'd2
  } state_e;

  // PC value the CPU fetches first after a reset; monitors compare against it too
  localparam logic [15:0] RESET_HANDLER = 16'hFFFE;

  // Default protected-region bases used by the monitors
  localparam logic [15:0] SMEM_BASE = 16'hA000;
  localparam logic [15:0] ISR_BASE  = 16'hE000;

  // Bits needed to count 0..n-1, never fewer than one
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Generic saturating up-counter with synchronous clear.
// Latency: count visible one cycle after inc_i; clear and increment together yield 1.
// No backpressure: increments beyond all-ones are silently dropped.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic [W-1:0] base;

  // Clear first, then apply the increment on top so a same-cycle clear+inc lands on 1
  always_comb begin
    base  = clr_i ? '0 : cnt_q;
    cnt_d = base;
    if (inc_i && !(&base)) begin
      cnt_d = base + 1'b1;
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/viol_reset_seq.sv
// Turns monitor violation requests into a timed CPU reset pulse and checks the reboot.
// Latency: cpu_rst rises one cycle after a violation in IDLE; all outputs are registered.
// No backpressure: violations are ignored while a pulse or boot check is in progress.
module viol_reset_seq #(
  parameter int          NSRC          = 4,
  parameter int          HOLD_CYCLES   = 16,
  parameter int          BOOT_TIMEOUT  = 64,
  parameter logic [15:0] RESET_HANDLER = hwmod_pkg::RESET_HANDLER,
  parameter int          CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NSRC-1:0]  viol_in,
  input  logic [15:0]      pc,
  input  logic             cause_clr,
  output logic             cpu_rst,
  output logic [NSRC-1:0]  cause,
  output logic [CNT_W-1:0] viol_cnt,
  output logic             boot_fail,
  output logic             busy
);

  import hwmod_pkg::*;

  localparam int HOLD_W = cnt_width(HOLD_CYCLES);
  localparam int TO_W   = cnt_width(BOOT_TIMEOUT);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(BOOT_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic [NSRC-1:0]   cause_q, cause_d;
  logic              boot_fail_q, boot_fail_d;
  logic              busy_q;
  logic              trig;

  // Next-state logic; clear is applied first so a trigger or timeout in the same cycle wins
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    to_d        = to_q;
    cpu_rst_d   = cpu_rst_q;
    cause_d     = cause_clr ? '0 : cause_q;
    boot_fail_d = cause_clr ? 1'b0 : boot_fail_q;
    trig        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cpu_rst_d = 1'b0;
        if (|viol_in) begin
          trig      = 1'b1;
          state_d   = ST_ASSERT;
          hold_d    = '0;
          cpu_rst_d = 1'b1;
          cause_d   = viol_in;
        end
      end
      ST_ASSERT: begin
        cpu_rst_d = 1'b1;
        if (hold_q == HOLD_LAST) begin
          state_d   = ST_WAIT_BOOT;
          cpu_rst_d = 1'b0;
          to_d      = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_WAIT_BOOT: begin
        // Monitors stay high until the CPU reaches the vector, so viol_in is not looked at here
        cpu_rst_d = 1'b0;
        if (pc == RESET_HANDLER) begin
          state_d = ST_IDLE;
        end else if (to_q == TO_LAST) begin
          state_d     = ST_ASSERT;
          hold_d      = '0;
          cpu_rst_d   = 1'b1;
          boot_fail_d = 1'b1;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      default: begin
        state_d   = ST_ASSERT;
        hold_d    = '0;
        cpu_rst_d = 1'b1;
      end
    endcase
  end

  // State and output registers; reset forces a fresh full-length reset pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_ASSERT;
      hold_q      <= '0;
      to_q        <= '0;
      cpu_rst_q   <= 1'b1;
      cause_q     <= '0;
      boot_fail_q <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      to_q        <= to_d;
      cpu_rst_q   <= cpu_rst_d;
      cause_q     <= cause_d;
      boot_fail_q <= boot_fail_d;
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_viol_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (cause_clr),
    .inc_i (trig),
    .cnt_o (viol_cnt)
  );

  assign cpu_rst   = cpu_rst_q;
  assign cause     = cause_q;
  assign boot_fail = boot_fail_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_viol_reset_seq.sv
// Bench for viol_reset_seq: two instances (8-bit and 2-bit counters) share one stimulus.
// A cycle-timeline model predicts every output; directed sections pin literal values.
module tb_viol_reset_seq;

  localparam int H = 16;
  localparam int B = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  viol_in = '0;
  logic [15:0] pc = '0;
  logic        cause_clr = 1'b0;

  logic       cpu_rst_a, boot_fail_a, busy_a;
  logic [3:0] cause_a;
  logic [7:0] viol_cnt_a;
  logic       cpu_rst_b, boot_fail_b, busy_b;
  logic [3:0] cause_b;
  logic [1:0] viol_cnt_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  viol_reset_seq dut_a (
    .clk(clk), .reset(reset), .viol_in(viol_in), .pc(pc), .cause_clr(cause_clr),
    .cpu_rst(cpu_rst_a), .cause(cause_a), .viol_cnt(viol_cnt_a),
    .boot_fail(boot_fail_a), .busy(busy_a)
  );

  viol_reset_seq #(.CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .viol_in(viol_in), .pc(pc), .cause_clr(cause_clr),
    .cpu_rst(cpu_rst_b), .cause(cause_b), .viol_cnt(viol_cnt_b),
    .boot_fail(boot_fail_b), .busy(busy_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: m_t counts cycles since the current pulse began; high while m_t < H,
  // then m_t - H is the time spent waiting for the boot vector.
  bit         m_valid = 0;
  bit         m_idle;
  int         m_t;
  logic [3:0] m_cause;
  int         m_cnt_a, m_cnt_b;
  bit         m_bf;

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1; m_idle = 0; m_t = 0; m_cause = 0;
      m_cnt_a = 0; m_cnt_b = 0; m_bf = 0;
    end else if (m_valid) begin
      if (cause_clr) begin
        m_cause = 0; m_cnt_a = 0; m_cnt_b = 0; m_bf = 0;
      end
      if (m_idle) begin
        if (viol_in != 0) begin
          m_idle = 0; m_t = 0; m_cause = viol_in;
          if (m_cnt_a < 255) m_cnt_a++;
          if (m_cnt_b < 3) m_cnt_b++;
        end
      end else if (m_t < H) begin
        m_t++;
      end else if (pc == 16'hFFFE) begin
        m_idle = 1;
      end else if (m_t - H == B - 1) begin
        m_t = 0; m_bf = 1;
      end else begin
        m_t++;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("cpu_rst_a", cpu_rst_a, (!m_idle && m_t < H));
      chk("cpu_rst_b", cpu_rst_b, (!m_idle && m_t < H));
      chk("busy_a", busy_a, !m_idle);
      chk("busy_b", busy_b, !m_idle);
      chk("cause_a", cause_a, m_cause);
      chk("cause_b", cause_b, m_cause);
      chk("viol_cnt_a", viol_cnt_a, m_cnt_a);
      chk("viol_cnt_b", viol_cnt_b, m_cnt_b);
      chk("boot_fail_a", boot_fail_a, m_bf);
      chk("boot_fail_b", boot_fail_b, m_bf);
    end
  end

  task automatic step(input logic [3:0] v, input logic [15:0] p, input logic c, input logic r);
    viol_in = v; pc = p; cause_clr = c; reset = r;
    @(posedge clk); #1;
  endtask

  task automatic recover();
    int n = 0;
    while (busy_a && n < 300) begin
      step(4'h0, 16'hFFFE, 1'b0, 1'b0);
      n++;
    end
    chk("recover_idle", busy_a, 1'b0);
  endtask

  task automatic count_high(input string nm);
    int hi = 0;
    int n = 0;
    while (cpu_rst_a && n < 100) begin
      hi++;
      step(4'h0, 16'h0000, 1'b0, 1'b0);
      n++;
    end
    chk(nm, hi, H);
  endtask

  initial begin
    int lo;
    int rises;
    logic prev;

    // Power-on: one reset cycle, pulse of exactly H, pc match at cycle 17
    step(4'h0, 16'h0000, 1'b0, 1'b1);
    chk("por_rst_high", cpu_rst_a, 1'b1);
    chk("por_busy", busy_a, 1'b1);
    count_high("por_hold_len");
    step(4'h0, 16'hFFFE, 1'b0, 1'b0);
    chk("por_idle", busy_a, 1'b0);
    chk("por_cnt", viol_cnt_a, 8'd0);
    chk("por_cause", cause_a, 4'h0);

    // Single violation
    step(4'h1, 16'h0000, 1'b0, 1'b0);
    chk("single_rise", cpu_rst_a, 1'b1);
    chk("single_cause", cause_a, 4'h1);
    chk("single_cnt", viol_cnt_a, 8'd1);
    count_high("single_hold_len");
    chk("single_busy_wait", busy_a, 1'b1);
    recover();

    // Simultaneous sources, then held requests stay masked until IDLE
    step(4'h5, 16'h0000, 1'b0, 1'b0);
    rises = 0;
    prev = cpu_rst_a;
    repeat (40) begin
      step(4'hF, 16'h0000, 1'b0, 1'b0);
      if (cpu_rst_a && !prev) rises++;
      prev = cpu_rst_a;
    end
    chk("mask_no_retrigger", rises, 0);
    step(4'hF, 16'hFFFE, 1'b0, 1'b0);
    chk("mask_idle", busy_a, 1'b0);
    chk("mask_rst_low", cpu_rst_a, 1'b0);
    chk("multi_cause", cause_a, 4'h5);
    chk("multi_cnt", viol_cnt_a, 8'd2);
    step(4'hF, 16'h0000, 1'b0, 1'b0);
    chk("after_idle_trigger", cpu_rst_a, 1'b1);
    chk("after_idle_cause", cause_a, 4'hF);
    recover();

    // Clear, then boot timeout
    step(4'h0, 16'h0000, 1'b1, 1'b0);
    chk("clr_cnt", viol_cnt_a, 8'd0);
    chk("clr_cause", cause_a, 4'h0);
    step(4'h8, 16'h0000, 1'b0, 1'b0);
    count_high("to_hold_len");
    lo = 0;
    while (!cpu_rst_a && lo < 200) begin
      lo++;
      step(4'h0, 16'h0000, 1'b0, 1'b0);
    end
    chk("to_low_len", lo, B);
    chk("to_boot_fail", boot_fail_a, 1'b1);
    chk("to_cnt_same", viol_cnt_a, 8'd1);
    chk("to_cause_same", cause_a, 4'h8);
    count_high("to_retry_hold_len");
    recover();
    chk("to_then_idle", busy_a, 1'b0);

    // Four more triggers: 8-bit counter at 5, 2-bit counter saturates at 3
    repeat (4) begin
      step(4'h2, 16'h0000, 1'b0, 1'b0);
      recover();
    end
    chk("cnt_five", viol_cnt_a, 8'd5);
    chk("cnt_sat", viol_cnt_b, 2'd3);

    // Clear colliding with a trigger
    step(4'h2, 16'h0000, 1'b1, 1'b0);
    chk("coll_cause", cause_a, 4'h2);
    chk("coll_cnt_a", viol_cnt_a, 8'd1);
    chk("coll_cnt_b", viol_cnt_b, 2'd1);
    chk("coll_bf", boot_fail_a, 1'b0);

    // Reset in the middle of the boot wait
    repeat (18) step(4'h0, 16'h0000, 1'b0, 1'b0);
    chk("mid_in_wait", cpu_rst_a, 1'b0);
    step(4'h0, 16'h0000, 1'b0, 1'b1);
    chk("mid_rst_high", cpu_rst_a, 1'b1);
    chk("mid_busy", busy_a, 1'b1);
    chk("mid_cause", cause_a, 4'h0);
    chk("mid_cnt", viol_cnt_a, 8'd0);
    chk("mid_bf", boot_fail_a, 1'b0);
    count_high("mid_hold_len");
    recover();

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      logic [3:0]  v;
      logic [15:0] p;
      v = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      p = ($urandom_range(0, 24) == 0) ? 16'hFFFE : 16'($urandom);
      step(v, p, ($urandom_range(0, 15) == 0), ($urandom_range(0, 299) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
